// File: rtl/div_rv_iter.sv
// Iterative radix-2 restoring divider for the EXE stage.
// Covers DIV/DIVU/REM/REMU with RISC-V divide-by-zero and overflow results.
module div_rv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            req_in,
  input  logic [1:0]      op_in,
  input  logic [XLEN-1:0] dividend_in,
  input  logic [XLEN-1:0] divisor_in,
  input  logic            flush_in,
  output logic            busy_out,
  output logic            ready_out,
  output logic [XLEN-1:0] result_out,
  output logic            dbz_out
);

  localparam int CNT_W = $clog2(XLEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             rem_sel;
  logic             neg_q;
  logic             neg_r;
  logic             spec;
  logic             dbz_p;
  logic [XLEN:0]    rem;
  logic [XLEN-1:0]  quot;
  logic [XLEN-1:0]  dvs;

  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [XLEN-1:0]  a_abs;
  logic [XLEN-1:0]  b_abs;
  logic             dbz_c;
  logic             ovf_c;
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    trial;
  logic [XLEN-1:0]  q_fix;
  logic [XLEN-1:0]  r_fix;

  assign busy_out = (state != S_IDLE);

  // Operand conditioning and one restoring step, all combinational.
  always_comb begin
    is_signed = ~op_in[0];
    a_neg     = is_signed & dividend_in[XLEN-1];
    b_neg     = is_signed & divisor_in[XLEN-1];
    a_abs     = a_neg ? (~dividend_in + 1'b1) : dividend_in;
    b_abs     = b_neg ? (~divisor_in + 1'b1) : divisor_in;
    dbz_c     = (divisor_in == '0);
    ovf_c     = is_signed && (dividend_in == MIN_NEG)
                && (divisor_in == '1);
    shifted   = {rem[XLEN-1:0], quot[XLEN-1]};
    trial     = shifted - {1'b0, dvs};
    q_fix     = neg_q ? (~quot + 1'b1) : quot;
    r_fix     = neg_r ? (~rem[XLEN-1:0] + 1'b1) : rem[XLEN-1:0];
  end

  // Control FSM and datapath; special results skip CALC and
  // spend an extra FIX cycle so their latency is fixed at two.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rem_sel    <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      spec       <= 1'b0;
      dbz_p      <= 1'b0;
      rem        <= '0;
      quot       <= '0;
      dvs        <= '0;
      ready_out  <= 1'b0;
      result_out <= '0;
      dbz_out    <= 1'b0;
    end else begin
      ready_out <= 1'b0;
      if (flush_in) begin
        state <= S_IDLE;
        spec  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (req_in) begin
              rem_sel <= op_in[1];
              dvs     <= b_abs;
              if (dbz_c || ovf_c) begin
                state <= S_FIX;
                spec  <= 1'b1;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
                dbz_p <= dbz_c;
                cnt   <= '0;
                quot  <= dbz_c ? '1 : dividend_in;
                rem   <= dbz_c ? {1'b0, dividend_in} : '0;
              end else begin
                state <= S_CALC;
                spec  <= 1'b0;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                dbz_p <= 1'b0;
                cnt   <= CNT_W'(XLEN);
                quot  <= a_abs;
                rem   <= '0;
              end
            end
          end
          S_CALC: begin
            if (!trial[XLEN]) begin
              rem  <= trial;
              quot <= {quot[XLEN-2:0], 1'b1};
            end else begin
              rem  <= shifted;
              quot <= {quot[XLEN-2:0], 1'b0};
            end
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state <= S_FIX;
            end
          end
          S_FIX: begin
            if (spec) begin
              spec <= 1'b0;
            end else begin
              state      <= S_IDLE;
              ready_out  <= 1'b1;
              result_out <= rem_sel ? r_fix : q_fix;
              dbz_out    <= dbz_p;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_rv_iter.sv
// Directed bench for div_rv_iter at XLEN=32 and XLEN=64.
// Checks results, flags, latency, flush, reset and back-to-back issue.
module tb_div_rv_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req32;
  logic        req64;
  logic [1:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic        flush;

  logic        busy32, rdy32, dbz32;
  logic [31:0] res32;
  logic        busy64, rdy64, dbz64;
  logic [63:0] res64;

  int n_pass = 0;
  int n_tot  = 0;
  int rcnt   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rdy32) rcnt++;

  div_rv_iter #(.XLEN(32)) u32 (
    .clk_in(clk), .reset_in(rst), .req_in(req32), .op_in(op),
    .dividend_in(a[31:0]), .divisor_in(b[31:0]), .flush_in(flush),
    .busy_out(busy32), .ready_out(rdy32), .result_out(res32),
    .dbz_out(dbz32)
  );

  div_rv_iter #(.XLEN(64)) u64 (
    .clk_in(clk), .reset_in(rst), .req_in(req64), .op_in(op),
    .dividend_in(a), .divisor_in(b), .flush_in(flush),
    .busy_out(busy64), .ready_out(rdy64), .result_out(res64),
    .dbz_out(dbz64)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    n_tot++;
    if (got !== want)
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    else
      n_pass++;
  endtask

  task automatic wait_rdy(input bit wide, output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      lat++;
      if (wide ? rdy64 : rdy32) break;
    end
  endtask

  task automatic do_op(input string tag, input bit wide,
                       input logic [1:0] o, input logic [63:0] x,
                       input logic [63:0] y, input logic [63:0] er,
                       input bit ed, input int el);
    int lat;
    @(negedge clk);
    op = o; a = x; b = y;
    if (wide) req64 = 1'b1; else req32 = 1'b1;
    @(posedge clk); #1;
    req32 = 1'b0; req64 = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    op = 2'($urandom);
    chk({tag, ".busy"}, wide ? busy64 : busy32, 1);
    wait_rdy(wide, lat);
    chk({tag, ".lat"}, 64'(lat), 64'(el));
    chk({tag, ".res"}, wide ? res64 : {32'h0, res32}, er);
    chk({tag, ".dbz"}, wide ? dbz64 : dbz32, 64'(ed));
    chk({tag, ".busy_rdy"}, wide ? busy64 : busy32, 0);
  endtask

  task automatic abort_run(input bit use_rst);
    int r0;
    @(negedge clk);
    op = 2'b01; a = 64'd1000; b = 64'd3; req32 = 1'b1;
    @(posedge clk); #1;
    req32 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    r0 = rcnt;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    chk(use_rst ? "rst.busy" : "fl.busy", busy32, 0);
    if (use_rst) begin
      chk("rst.res", res32, 0);
      chk("rst.dbz", dbz32, 0);
      chk("rst.rdy", rdy32, 0);
    end else begin
      chk("fl.res_kept", res32, 4);
      chk("fl.dbz_kept", dbz32, 0);
    end
    repeat (40) @(posedge clk);
    #1;
    chk(use_rst ? "rst.no_rdy" : "fl.no_rdy", 64'(rcnt - r0), 0);
  endtask

  logic [31:0] hx [3] = '{32'd50, 32'd17, 32'hFFFF_FFF7};
  logic [31:0] hy [3] = '{32'd5, 32'd5, 32'd3};
  logic [1:0]  ho [3] = '{2'b01, 2'b11, 2'b00};
  logic [31:0] he [3] = '{32'd10, 32'd2, 32'hFFFF_FFFD};

  initial begin
    int lat;
    rst = 1'b1; req32 = 1'b0; req64 = 1'b0; flush = 1'b0;
    op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", busy32, 0);
    chk("reset.rdy", rdy32, 0);
    chk("reset.res", res32, 0);
    chk("reset.dbz", dbz32, 0);
    chk("reset.res64", res64, 0);
    @(negedge clk); rst = 1'b0;

    do_op("divu_100_7", 0, 2'b01, 100, 7, 14, 0, 33);
    do_op("remu_100_7", 0, 2'b11, 100, 7, 2, 0, 33);
    do_op("div_m7_2", 0, 2'b00, 64'hFFFF_FFF9, 2,
          64'hFFFF_FFFD, 0, 33);
    do_op("rem_m7_2", 0, 2'b10, 64'hFFFF_FFF9, 2,
          64'hFFFF_FFFF, 0, 33);
    do_op("rem_7_m2", 0, 2'b10, 7, 64'hFFFF_FFFE, 1, 0, 33);
    do_op("divu_big", 0, 2'b01, 64'hFFFF_FFF9, 2,
          64'h7FFF_FFFC, 0, 33);
    do_op("div_ovf", 0, 2'b00, 64'h8000_0000, 64'hFFFF_FFFF,
          64'h8000_0000, 0, 2);
    do_op("rem_ovf", 0, 2'b10, 64'h8000_0000, 64'hFFFF_FFFF,
          0, 0, 2);
    do_op("divu_0_9", 0, 2'b01, 0, 9, 0, 0, 33);
    do_op("divu_dbz", 0, 2'b01, 5, 0, 64'hFFFF_FFFF, 1, 2);
    do_op("rem_dbz", 0, 2'b10, 64'hFFFF_FFFB, 0,
          64'hFFFF_FFFB, 1, 2);
    do_op("divu_8_2", 0, 2'b01, 8, 2, 4, 0, 33);

    abort_run(0);
    do_op("remu_after_fl", 0, 2'b11, 1000, 3, 1, 0, 33);
    abort_run(1);
    do_op("div_after_rst", 0, 2'b00, 64'hFFFF_FF9C, 7,
          64'hFFFF_FFF2, 0, 33);

    @(negedge clk);
    op = ho[0]; a = 64'(hx[0]); b = 64'(hy[0]); req32 = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (i < 2) begin
        op = ho[i+1]; a = 64'(hx[i+1]); b = 64'(hy[i+1]);
      end else begin
        req32 = 1'b0;
      end
      wait_rdy(0, lat);
      chk($sformatf("hold%0d.lat", i), 64'(lat), 33);
      chk($sformatf("hold%0d.res", i), res32, he[i]);
      @(posedge clk);
    end
    #1;
    chk("hold.idle", busy32, 0);

    do_op("divu64", 1, 2'b01, 64'h8000_0000_0000_0000, 3,
          64'h2AAA_AAAA_AAAA_AAAA, 0, 65);
    do_op("rem64_m", 1, 2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 2,
          64'hFFFF_FFFF_FFFF_FFFF, 0, 65);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/div_rv_iter.md
Name: div_rv_iter

Overview:
- Parametrised iterative radix-2 restoring divider for the EXE stage.
- Implements all four RISC-V M-extension divide ops (DIV, DIVU, REM, REMU) at configurable XLEN.
- Handles signed operands, divide-by-zero and signed overflow per the RISC-V ISA; adds pulse handshake, busy indication and pipeline flush.
- Sits beside the multiplier; EXE control issues one op at a time and stalls on busy_out.

Parameters:
- XLEN, 32, operand/result width; legal 8..64.
- CNT_W (localparam), $clog2(XLEN+1), iteration counter width.

Ports:
- clk_in  input  1  clock, rising edge
- reset_in  input  1  synchronous, active-high reset
- req_in  input  1  start pulse; sampled only when busy_out=0
- op_in  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with req_in
- dividend_in  input  XLEN  rs1 operand; sampled with req_in
- divisor_in  input  XLEN  rs2 operand; sampled with req_in
- flush_in  input  1  abort current op (pipeline kill)
- busy_out  output  1  high while an op is in flight (state != IDLE)
- ready_out  output  1  one-cycle pulse, result_out valid
- result_out  output  XLEN  quotient or remainder; holds until next ready_out
- dbz_out  output  1  divide-by-zero flag, valid with ready_out, held like result_out

Behaviour:
- Reset: state IDLE; ready_out=0, busy_out=0, dbz_out=0, result_out=0; counter and datapath registers cleared.
- States: IDLE, CALC, FIX.
- IDLE with req_in=1 and flush_in=0 (accept edge E0):
  - Latch op, operand signs, |dividend|, |divisor|.
  - For DIVU/REMU, or signed ops with a non-negative operand, the absolute value is the raw operand.
  - Divisor==0 or signed overflow -> FIX with the special result preloaded.
  - Otherwise -> CALC with counter=XLEN.
- Dividend==0 is not a special case; it takes the normal CALC path.
- CALC: one restoring step per cycle.
  - Partial remainder is XLEN+1 bits; shift {rem,quot} left one bit.
  - Trial subtract divisor; if non-negative, keep the difference and set quotient LSB=1, else restore and set LSB=0.
  - Counter decrements each cycle; exits to FIX after exactly XLEN CALC cycles.
- FIX: one cycle, then -> IDLE.
  - Sign fix: quotient negated when signed op and operand signs differ.
  - Remainder takes the sign of the dividend.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU) into result_out; ready_out<=1 at the FIX exit edge.
- Latency, measured from the accept edge to the edge at which ready_out rises:
  - Normal ops: XLEN+1.
  - Special cases: 2.
- ready_out is high exactly one cycle, and busy_out is already 0 in that cycle. A new req_in in that same cycle is accepted (back-to-back issue).
- Divide-by-zero:
  - Quotient = all ones for both DIV and DIVU.
  - Remainder = dividend unchanged.
  - dbz_out=1 for both quotient and remainder ops. dbz_out=0 for every other completion.
- Signed overflow (DIV/REM, dividend = -2^(XLEN-1), divisor = -1): quotient = dividend, remainder = 0, dbz_out=0.
- Operand inputs may change after E0 without affecting the result.
- req_in while busy_out=1 is ignored. It is not queued.
- flush_in=1 in any state -> IDLE at next edge.
  - No ready_out is issued for the aborted op; result_out and dbz_out keep their previous values.
  - flush_in has priority over a simultaneous req_in.
- reset_in mid-operation: same abort, plus all outputs return to reset values.
- No state other than IDLE is reachable without a prior accept. Unused state encodings decode to IDLE.

Test Plan:
- DIVU 100/7 -> result_out=14, ready_out rises 33 edges after accept; REMU 100/7 -> 2; dbz_out=0; busy_out low in the ready cycle.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REM 7/-2 -> 1; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- DIVU 5/0 -> 0xFFFFFFFF with dbz_out=1, ready 2 edges after accept; REM -5/0 -> 0xFFFFFFFB with dbz_out=1; following DIVU 8/2 -> 4 with dbz_out=0.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same operands -> 0, both in 2-edge latency with dbz_out=0; DIVU 0/9 -> 0 after 33 edges.
- Accept DIVU 1000/3, assert flush_in at CALC cycle 10:
  - busy_out drops next cycle; no ready_out pulse.
  - Immediate REMU 1000/3 -> 1.
  - Repeat the sequence with reset_in instead of flush_in: outputs go to 0.
- Hold req_in high continuously with changing operands -> exactly one accept per completion, results match operands at each accept edge.
- XLEN=64 instance: DIVU 2^63/3 -> 0x2AAAAAAAAAAAAAAA after 65 edges.
